// File: rtl/llpage_alloc_if.sv
// Bus between the page allocator and its requesters/reclaimers.
// Valid/ready: a transfer happens on a rising edge where srdy and drdy are both 1; srdy holds its data stable until then.
interface llpage_alloc_if #(
  parameter int lpsz    = 8,
  parameter int sources = 4,
  parameter int sinks   = 4
);
  logic [sources-1:0]    pgreq;
  logic [sources-1:0]    pgack;
  logic [sources-1:0]    lprq_srdy;
  logic [sources-1:0]    lprq_drdy;
  logic [lpsz-1:0]       lprq_page;
  logic [sinks-1:0]      lprt_srdy;
  logic [sinks-1:0]      lprt_drdy;
  logic [sinks*lpsz-1:0] lprt_page_list;
  logic [lpsz:0]         free_count;

  modport master (
    output pgreq, lprq_drdy, lprt_srdy, lprt_page_list,
    input  pgack, lprq_srdy, lprq_page, lprt_drdy, free_count
  );

  modport slave (
    input  pgreq, lprq_drdy, lprt_srdy, lprt_page_list,
    output pgack, lprq_srdy, lprq_page, lprt_drdy, free_count
  );
endinterface

// File: rtl/llpage_alloc.sv
// Linked-list page allocator: circular free list of 2**lpsz pages, filled at reset,
// handed to requesters one at a time and refilled by reclaimers, both round-robin.
module llpage_alloc #(
  parameter int lpsz    = 8,
  parameter int sources = 4,
  parameter int sinks   = 4
) (
  input  logic            clk,
  input  logic            reset,
  llpage_alloc_if.slave   bus,
  output logic            dbg_state
);
  localparam int pool  = 2 ** lpsz;
  localparam int src_w = (sources > 1) ? $clog2(sources) : 1;
  localparam int snk_w = (sinks > 1) ? $clog2(sinks) : 1;

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_e;

  state_e             state_q, state_d;
  logic               in_init, in_run;
  logic [lpsz-1:0]    rd_ptr_q, rd_ptr_d;
  logic [lpsz-1:0]    wr_ptr_q, wr_ptr_d;
  logic [lpsz:0]      count_q, count_d;
  logic [sources-1:0] pgack_q, pgack_d;
  logic [sources-1:0] srdy_q, srdy_d;
  logic [lpsz-1:0]    page_q, page_d;
  logic [src_w-1:0]   rr_src_q, rr_src_d;
  logic [snk_w-1:0]   rr_snk_q, rr_snk_d;

  logic [lpsz-1:0]    mem_q [pool];
  logic               mem_we;
  logic [lpsz-1:0]    mem_wdata;

  logic [sources-1:0] req_mask;
  logic [src_w-1:0]   src_idx, src_win;
  logic               src_found;
  logic [snk_w-1:0]   snk_idx, snk_win;
  logic               snk_found;
  logic [lpsz-1:0]    rt_page [sinks];
  logic [lpsz-1:0]    snk_page;
  logic               pop, push;

  for (genvar g = 0; g < sinks; g++) begin : g_unpack
    assign rt_page[g] = bus.lprt_page_list[g*lpsz +: lpsz];
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_INIT;
    else       state_q <= state_d;
  end

  // FSM: next state; INIT leaves once the last page number has been written
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT: if (&wr_ptr_q) state_d = ST_RUN;
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_INIT;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_init = (state_q == ST_INIT);
    in_run  = (state_q == ST_RUN);
  end

  assign dbg_state = (state_q == ST_RUN);

  always_comb begin
    req_mask  = bus.pgreq & ~pgack_q;
    src_found = 1'b0;
    src_win   = '0;
    src_idx   = '0;
    for (int i = 0; i < sources; i++) begin
      src_idx = src_w'((int'(rr_src_q) + i) % sources);
      if (!src_found && req_mask[src_idx]) begin
        src_found = 1'b1;
        src_win   = src_idx;
      end
    end
  end

  always_comb begin
    snk_found = 1'b0;
    snk_win   = '0;
    snk_idx   = '0;
    for (int i = 0; i < sinks; i++) begin
      snk_idx = snk_w'((int'(rr_snk_q) + i) % sinks);
      if (!snk_found && bus.lprt_srdy[snk_idx]) begin
        snk_found = 1'b1;
        snk_win   = snk_idx;
      end
    end
    snk_page = rt_page[snk_win];
  end

  // count never exceeds the pool size, so its MSB alone flags a full list
  assign pop  = in_run && (count_q != '0) && (srdy_q == '0) && src_found;
  assign push = in_run && !count_q[lpsz] && snk_found && !reset;

  assign bus.lprt_drdy  = push ? (sinks'(1) << snk_win) : '0;
  assign bus.pgack      = pgack_q;
  assign bus.lprq_srdy  = srdy_q;
  assign bus.lprq_page  = page_q;
  assign bus.free_count = count_q;

  always_comb begin
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    pgack_d   = '0;
    srdy_d    = srdy_q & ~bus.lprq_drdy;
    page_d    = page_q;
    rr_src_d  = rr_src_q;
    rr_snk_d  = rr_snk_q;
    mem_we    = 1'b0;
    mem_wdata = snk_page;
    if (in_init) begin
      mem_we    = 1'b1;
      mem_wdata = wr_ptr_q;
      wr_ptr_d  = wr_ptr_q + 1'b1;
      count_d   = count_q + 1'b1;
    end
    if (pop) begin
      pgack_d  = sources'(1) << src_win;
      srdy_d   = sources'(1) << src_win;
      page_d   = mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + 1'b1;
      rr_src_d = (src_win == src_w'(sources - 1)) ? '0 : src_win + 1'b1;
    end
    if (push) begin
      mem_we   = 1'b1;
      wr_ptr_d = wr_ptr_q + 1'b1;
      rr_snk_d = (snk_win == snk_w'(sinks - 1)) ? '0 : snk_win + 1'b1;
    end
    if (pop && !push)      count_d = count_q - 1'b1;
    else if (push && !pop) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      pgack_q  <= '0;
      srdy_q   <= '0;
      page_q   <= '0;
      rr_src_q <= '0;
      rr_snk_q <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      pgack_q  <= pgack_d;
      srdy_q   <= srdy_d;
      page_q   <= page_d;
      rr_src_q <= rr_src_d;
      rr_snk_q <= rr_snk_d;
    end
  end

  // Read and write addresses only meet when the list is empty or full, where pop or push is blocked
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_ptr_q] <= mem_wdata;
  end
endmodule

// File: tb/tb_llpage_alloc.sv
// Bench for llpage_alloc (lpsz=4, 4 sources, 4 sinks): directed table and sequences,
// then random traffic against a free-list queue model.
module tb_llpage_alloc;
  localparam int LPSZ = 4;
  localparam int NSRC = 4;
  localparam int NSNK = 4;
  localparam int POOL = 16;

  logic clk = 1'b0;
  logic reset;
  logic dbg_state;
  int   errors = 0;
  int   checks = 0;

  llpage_alloc_if #(.lpsz(LPSZ), .sources(NSRC), .sinks(NSNK)) bus();

  llpage_alloc #(.lpsz(LPSZ), .sources(NSRC), .sinks(NSNK)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0] mask;
    int         src;
    logic [3:0] page;
    logic [4:0] cnt;
  } vec_t;

  vec_t vecs[8];
  logic [3:0] exp_q[$];

  int         got_src, n, grants, last_cyc, cyc;
  logic [3:0] got_page;
  logic [4:0] got_cnt;
  int         exp_order[5];
  logic [3:0] drain_pages[10];

  int         out_src, pred_grant, pred_snk, rr_s, rr_k, req_p, snk_p;
  logic [3:0] out_page, req_v, sink_v, snk_acc, pending;
  logic [3:0] sink_pg[4];
  bit         acc_prev;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  function automatic logic [31:0] oh(input int i);
    if (i < 0) return 32'd0;
    return 32'd1 << i;
  endfunction

  function automatic int oh2idx(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  // driver tasks
  task automatic init_walk();
    for (int k = 1; k <= POOL; k++) begin
      @(negedge clk);
      chk("init_count", 32'(bus.free_count), 32'(k));
      chk("init_state", 32'(dbg_state), (k == POOL) ? 32'd1 : 32'd0);
      chk("init_pgack", 32'(bus.pgack), 32'd0);
      #1;
      chk("init_drdy", 32'(bus.lprt_drdy), 32'd0);
    end
  endtask

  task automatic alloc(input logic [3:0] mask, output int src, output logic [3:0] page,
                       output logic [4:0] cnt);
    int w;
    src = -1; page = '0; cnt = '0;
    @(negedge clk);
    bus.pgreq = mask;
    bus.lprq_drdy = '1;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (bus.pgack == '0 && w < 20);
    chk("alloc_ack_seen", 32'(bus.pgack != '0), 32'd1);
    if (bus.pgack != '0) begin
      src  = oh2idx(bus.pgack);
      page = bus.lprq_page;
      cnt  = bus.free_count;
      chk("alloc_srdy_eq_ack", 32'(bus.lprq_srdy), 32'(bus.pgack));
    end
    bus.pgreq = '0;
    @(negedge clk);
    chk("alloc_ack_one_cycle", 32'(bus.pgack), 32'd0);
    chk("alloc_srdy_clear", 32'(bus.lprq_srdy), 32'd0);
  endtask

  task automatic reclaim(input int k, input logic [3:0] pg);
    int w;
    @(negedge clk);
    bus.lprt_srdy[k] = 1'b1;
    bus.lprt_page_list[k*LPSZ +: LPSZ] = pg;
    #1;
    w = 0;
    while (!bus.lprt_drdy[k] && w < 20) begin
      @(negedge clk);
      #1;
      w++;
    end
    chk("reclaim_drdy", 32'(bus.lprt_drdy), oh(k));
    @(negedge clk);
    bus.lprt_srdy[k] = 1'b0;
  endtask

  initial begin
    vecs[0] = '{4'b0100, 2, 4'd0, 5'd15};
    vecs[1] = '{4'b0100, 2, 4'd1, 5'd14};
    vecs[2] = '{4'b0001, 0, 4'd2, 5'd13};
    vecs[3] = '{4'b1001, 3, 4'd3, 5'd12};
    vecs[4] = '{4'b0011, 0, 4'd4, 5'd11};
    vecs[5] = '{4'b1010, 1, 4'd5, 5'd10};
    vecs[6] = '{4'b1101, 2, 4'd6, 5'd9};
    vecs[7] = '{4'b1001, 3, 4'd7, 5'd8};
    exp_order   = '{0, 1, 2, 3, 0};
    drain_pages = '{4'd14, 4'd15, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd10};

    // reset, then INIT fills the pool with requests and reclaims ignored
    reset = 1'b1;
    bus.pgreq = 4'b1111;
    bus.lprq_drdy = '0;
    bus.lprt_srdy = 4'b1111;
    bus.lprt_page_list = '0;
    repeat (3) @(negedge clk);
    chk("rst_count", 32'(bus.free_count), 32'd0);
    chk("rst_pgack", 32'(bus.pgack), 32'd0);
    chk("rst_srdy", 32'(bus.lprq_srdy), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    reset = 1'b0;
    init_walk();
    bus.pgreq = '0;
    bus.lprt_srdy = '0;

    // table of single allocations with round-robin priority
    for (int i = 0; i < 8; i++) begin
      alloc(vecs[i].mask, got_src, got_page, got_cnt);
      chk("tbl_src", 32'(got_src), 32'(vecs[i].src));
      chk("tbl_page", 32'(got_page), 32'(vecs[i].page));
      chk("tbl_count", 32'(got_cnt), 32'(vecs[i].cnt));
    end

    // all four requesting; source 0 asks for a second page
    @(negedge clk);
    bus.pgreq = 4'b1111;
    bus.lprq_drdy = '1;
    grants = 0; last_cyc = -100; cyc = 0;
    while (grants < 5 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (bus.pgack != '0) begin
        got_src = oh2idx(bus.pgack);
        chk("rr_order", 32'(got_src), 32'(exp_order[grants]));
        chk("rr_page", 32'(bus.lprq_page), 32'(8 + grants));
        if (grants > 0) chk("grant_gap", 32'(cyc - last_cyc >= 2), 32'd1);
        last_cyc = cyc;
        if (!(got_src == 0 && grants == 0)) bus.pgreq[got_src] = 1'b0;
        grants++;
      end
    end
    chk("rr_grants", 32'(grants), 32'd5);
    bus.pgreq = '0;
    @(negedge clk);
    chk("rr_count", 32'(bus.free_count), 32'd3);

    for (int i = 0; i < 7; i++) reclaim(i % NSNK, 4'(i));
    chk("refill_count", 32'(bus.free_count), 32'd10);

    // pop and push land on the same edge
    @(negedge clk);
    bus.pgreq[1] = 1'b1;
    bus.lprt_srdy[2] = 1'b1;
    bus.lprt_page_list[2*LPSZ +: LPSZ] = 4'hA;
    #1;
    chk("same_cycle_drdy", 32'(bus.lprt_drdy), 32'b0100);
    @(negedge clk);
    bus.pgreq = '0;
    bus.lprt_srdy = '0;
    chk("same_cycle_ack", 32'(bus.pgack), 32'b0010);
    chk("same_cycle_page", 32'(bus.lprq_page), 32'd13);
    chk("same_cycle_count", 32'(bus.free_count), 32'd10);

    for (int i = 0; i < 10; i++) begin
      alloc(4'b0001, got_src, got_page, got_cnt);
      chk("drain_page", 32'(got_page), 32'(drain_pages[i]));
      chk("drain_count", 32'(got_cnt), 32'(9 - i));
    end

    // empty list: request waits, a reclaim then feeds it
    @(negedge clk);
    bus.pgreq[0] = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("empty_no_ack", 32'(bus.pgack), 32'd0);
    end
    chk("empty_count", 32'(bus.free_count), 32'd0);
    bus.lprt_srdy[1] = 1'b1;
    bus.lprt_page_list[1*LPSZ +: LPSZ] = 4'd5;
    #1;
    chk("empty_drdy", 32'(bus.lprt_drdy), 32'b0010);
    @(negedge clk);
    bus.lprt_srdy = '0;
    #1;
    chk("empty_drdy_once", 32'(bus.lprt_drdy), 32'd0);
    chk("empty_count_up", 32'(bus.free_count), 32'd1);
    @(negedge clk);
    chk("empty_ack", 32'(bus.pgack), 32'b0001);
    chk("empty_page", 32'(bus.lprq_page), 32'd5);
    chk("empty_count_dn", 32'(bus.free_count), 32'd0);
    bus.pgreq = '0;

    // reset in the middle of an unaccepted allocation
    reclaim(3, 4'd7);
    @(negedge clk);
    bus.pgreq = 4'b1000;
    bus.lprq_drdy = '0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.pgack == '0 && n < 20);
    chk("midrst_ack", 32'(bus.pgack), 32'b1000);
    bus.pgreq = '0;
    @(negedge clk);
    chk("midrst_hold", 32'(bus.lprq_srdy), 32'b1000);
    chk("midrst_page", 32'(bus.lprq_page), 32'd7);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_srdy", 32'(bus.lprq_srdy), 32'd0);
    chk("midrst_pgack", 32'(bus.pgack), 32'd0);
    chk("midrst_count", 32'(bus.free_count), 32'd0);
    chk("midrst_state", 32'(dbg_state), 32'd0);
    reset = 1'b0;
    init_walk();

    // random traffic against a queue model of the free list
    exp_q.delete();
    for (int p = 0; p < POOL; p++) exp_q.push_back(4'(p));
    out_src = -1; pred_grant = -1; rr_s = 0; rr_k = 0; acc_prev = 1'b0;
    req_v = '0; sink_v = '0; snk_acc = '0; out_page = '0;
    for (int k = 0; k < NSNK; k++) sink_pg[k] = '0;
    for (int ph = 0; ph < 3; ph++) begin
      req_p = (ph == 0) ? 60 : (ph == 1) ? 10 : 35;
      snk_p = (ph == 0) ? 10 : (ph == 1) ? 70 : 35;
      for (int c = 0; c < 250; c++) begin
        @(negedge clk);
        if (acc_prev) out_src = -1;
        chk("rnd_pgack", 32'(bus.pgack), oh(pred_grant));
        if (pred_grant >= 0) begin
          chk("rnd_page", 32'(bus.lprq_page), 32'(exp_q[0]));
          out_page = exp_q.pop_front();
          out_src = pred_grant;
          rr_s = (pred_grant + 1) % NSRC;
        end
        chk("rnd_srdy", 32'(bus.lprq_srdy), oh(out_src));
        if (out_src >= 0) chk("rnd_page_hold", 32'(bus.lprq_page), 32'(out_page));
        chk("rnd_count", 32'(bus.free_count), 32'(exp_q.size()));
        for (int s = 0; s < NSRC; s++) begin
          if (bus.pgack[s]) req_v[s] = 1'b0;
          else if (!req_v[s] && int'($urandom_range(0, 99)) < req_p) req_v[s] = 1'b1;
        end
        for (int k = 0; k < NSNK; k++) begin
          if (sink_v[k] && snk_acc[k]) sink_v[k] = 1'b0;
          if (!sink_v[k] && int'($urandom_range(0, 99)) < snk_p) begin
            sink_v[k] = 1'b1;
            sink_pg[k] = 4'($urandom);
          end
          bus.lprt_page_list[k*LPSZ +: LPSZ] = sink_pg[k];
        end
        bus.pgreq = req_v;
        bus.lprq_drdy = 4'($urandom);
        bus.lprt_srdy = sink_v;
        #1;
        pred_snk = -1;
        if (exp_q.size() < POOL)
          for (int i = 0; i < NSNK; i++)
            if (pred_snk < 0 && sink_v[(rr_k + i) % NSNK]) pred_snk = (rr_k + i) % NSNK;
        chk("rnd_drdy", 32'(bus.lprt_drdy), oh(pred_snk));
        snk_acc = bus.lprt_drdy & bus.lprt_srdy;
        pending = req_v & ~bus.pgack;
        pred_grant = -1;
        if (out_src < 0 && exp_q.size() > 0)
          for (int i = 0; i < NSRC; i++)
            if (pred_grant < 0 && pending[(rr_s + i) % NSRC]) pred_grant = (rr_s + i) % NSRC;
        if (pred_snk >= 0) begin
          exp_q.push_back(sink_pg[pred_snk]);
          rr_k = (pred_snk + 1) % NSNK;
        end
        acc_prev = (out_src >= 0) && bus.lprq_drdy[out_src];
      end
    end
    bus.pgreq = '0;
    bus.lprt_srdy = '0;

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
